// File: rtl/booth_radix4_seq.sv
// Iterative radix-4 Booth multiplier with a valid/ready handshake on both sides. It retires one Booth digit per clock.
// Optional BOOTH_ZERO_SKIP_EN: a zero operand goes straight to DONE with a zero product.
//
// state  | meaning
// S_IDLE | ready for an operand pair
// S_CALC | one Booth digit retired per clock, cnt_q counts down
// S_DONE | product held until out_ready
module booth_radix4_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product
);

   localparam int N  = WIDTH / 2 + 1;
   localparam int E  = WIDTH + 2;
   localparam int A  = WIDTH + 3;
   localparam int CW = $clog2(N + 1);

   if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("booth_radix4_seq: WIDTH must be even and >= 4");
   end

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [A-1:0]    acc_q;
   logic [E-1:0]    m_q;
   logic [E-1:0]    q_q;
   logic            qm1_q;
   logic [CW-1:0]   cnt_q;

   logic            zero_op;
   logic            last_iter;
   logic [A-1:0]    m_ext;
   logic [A-1:0]    sel;
   logic [A-1:0]    acc_sum;
   logic [A+E:0]    shifted;

`ifdef BOOTH_ZERO_SKIP_EN
   assign zero_op = (a == '0) || (b == '0);
`else
   assign zero_op = 1'b0;
`endif

   assign last_iter = (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = zero_op ? S_DONE : S_CALC;
         end
         S_CALC: if (last_iter) state_d = S_DONE;
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // One extra bit on the multiplicand so +/-2M always fits in the accumulator
   always_comb begin
      m_ext = {m_q[E-1], m_q};
      sel   = '0;
      case ({q_q[1:0], qm1_q})
         3'b001, 3'b010: sel = m_ext;
         3'b011:         sel = m_ext << 1;
         3'b100:         sel = -(m_ext << 1);
         3'b101, 3'b110: sel = -m_ext;
         default:        sel = '0;
      endcase
      acc_sum = acc_q + sel;
      shifted = $signed({acc_sum, q_q, qm1_q}) >>> 2;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q   <= '0;
         m_q     <= '0;
         q_q     <= '0;
         qm1_q   <= 1'b0;
         cnt_q   <= '0;
         product <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (in_valid) begin
               m_q   <= {{2{signed_mode & a[WIDTH-1]}}, a};
               q_q   <= {{2{signed_mode & b[WIDTH-1]}}, b};
               acc_q <= '0;
               qm1_q <= 1'b0;
               cnt_q <= CW'(N - 1);
               if (zero_op) product <= '0;
            end
            S_CALC: begin
               acc_q <= shifted[A+E:E+1];
               q_q   <= shifted[E:1];
               qm1_q <= shifted[0];
               if (last_iter) product <= shifted[2*WIDTH:1];
               else           cnt_q   <= cnt_q - 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_radix4_seq.sv
// Self-checking bench for booth_radix4_seq at WIDTH = 8.
// It runs directed corners, a mid-operation reset, backpressure and random pairs against a plain integer multiply.
module tb_booth_radix4_seq;

   localparam int W = 8;
   localparam int N = W / 2 + 1;

   logic           clk = 1'b0;
   logic           reset;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           signed_mode;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] product;

   int n_checks = 0;
   int n_errors = 0;

   booth_radix4_seq #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .signed_mode (signed_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .product     (product)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic sm);
      int ix, iy;
      ix = sm ? int'($signed(x)) : int'(x);
      iy = sm ? int'($signed(y)) : int'(y);
      return (2*W)'(ix * iy);
   endfunction

   // Latency is counted in clock edges after the accept edge until out_valid is seen high.
   // A zero-skipped operation is already in DONE right after the accept edge, so it counts 0 edges.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                         input int hold, input bit chk_lat, input string tag);
      logic [2*W-1:0] exp_p;
      int cyc;
      int exp_lat;
      exp_p   = ref_mul(ta, tb_v, ts);
      exp_lat = N;
`ifdef BOOTH_ZERO_SKIP_EN
      if (ta == '0 || tb_v == '0) exp_lat = 0;
`endif
      cyc = 0;
      while (!in_ready && cyc < 50) begin
         @(posedge clk); #1; cyc++;
      end
      if (!in_ready) check({tag, "_ready_timeout"}, 0, 1);
      a = ta; b = tb_v; signed_mode = ts; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
      cyc = 0;
      while (!out_valid && cyc < 50) begin
         @(posedge clk); #1; cyc++;
      end
      if (!out_valid) check({tag, "_valid_timeout"}, 0, 1);
      if (chk_lat) check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
      check({tag, "_product"}, product, exp_p);
      for (int i = 0; i < hold; i++) begin
         in_valid = (i % 2) == 0;
         a = W'($urandom); b = W'($urandom);
         @(posedge clk); #1;
         in_valid = 1'b0;
         check({tag, "_hold"}, {out_valid, in_ready, product}, {1'b1, 1'b0, exp_p});
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check({tag, "_release"}, {out_valid, in_ready}, 2'b01);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; signed_mode = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {out_valid, in_ready, product}, {1'b1 == 1'b0, 1'b1, 16'h0000});
      reset = 1'b0;

      run_op(8'h80, 8'h80, 1'b1, 0, 1'b1, "signed_corner");
      check("signed_corner_value", product, 16'h4000);
      run_op(8'hFF, 8'hFF, 1'b0, 0, 1'b1, "unsigned_max");
      check("unsigned_max_value", product, 16'hFE01);
      run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b1, "signed_ff");
      check("signed_ff_value", product, 16'h0001);
      run_op(8'hFD, 8'h07, 1'b1, 0, 1'b1, "mixed");
      check("mixed_value", product, 16'hFFEB);
      run_op(8'h07, 8'hFD, 1'b1, 0, 1'b1, "mixed_swap");
      check("mixed_swap_value", product, 16'hFFEB);
      run_op(8'h00, 8'h5A, 1'b0, 0, 1'b1, "zero_a");
      check("zero_a_value", product, 16'h0000);
      run_op(8'h5A, 8'h00, 1'b1, 0, 1'b1, "zero_b");
      run_op(8'h7F, 8'h81, 1'b1, 10, 1'b1, "backpressure");
      run_op(8'h0B, 8'hC3, 1'b0, 0, 1'b1, "after_backpressure");

      // Abort on the second CALC cycle
      a = 8'h55; b = 8'h66; signed_mode = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("mid_reset_state", {out_valid, in_ready, product}, {1'b0, 1'b1, 16'h0000});
      repeat (N + 2) begin
         @(posedge clk); #1;
         check("mid_reset_no_output", out_valid, 1'b0);
      end
      run_op(8'h12, 8'h34, 1'b0, 0, 1'b1, "after_reset");
      check("after_reset_value", product, 16'h03A8);

      for (int k = 0; k < 2000; k++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), ((k % 97) == 0) ? 3 : 0,
                (k % 50) == 0, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
